seq_tx_preamble: RTL and testbench

Serial frame transmitter; the transmit-side counterpart to the 1101 serial sequence detector.
- Accepts a parallel payload word over a valid/ready handshake.
- Emits one bit per clock on `dout`: the 4-bit sync preamble 1101, then the payload MSB-first, then a fixed idle gap of zeros.
- Feeds the detector's `din` directly in loopback benches and in the serial link top level.

---
 rtl/seq_tx_preamble_if.sv | 41 ++++
 rtl/seq_tx_preamble.sv | 129 ++++++++++++
 tb/tb_seq_tx_preamble.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_tx_preamble_if.sv
// ============================================================================
// seq_tx_preamble_if : payload handshake and serial output bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface seq_tx_preamble_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              dout;
   logic              dout_valid;
   logic              sync_mark;
   logic              frame_done;

   // Producer / line-observer side
   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  dout,
      input  dout_valid,
      input  sync_mark,
      input  frame_done
   );

   // Transmitter side
   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output dout,
      output dout_valid,
      output sync_mark,
      output frame_done
   );
endinterface

`default_nettype wire

// File: rtl/seq_tx_preamble.sv
// ============================================================================
// seq_tx_preamble : serial framer sending PREAMBLE, payload MSB-first, zero gap
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_tx_preamble #(
   parameter int          DATA_W   = 8,
   parameter int          GAP_LEN  = 2,
   parameter logic [3:0]  PREAMBLE = 4'b1101
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   seq_tx_preamble_if.slave  bus
);

   localparam int C_MAX1  = (DATA_W > 4) ? DATA_W : 4;
   localparam int C_MAX2  = (GAP_LEN > C_MAX1) ? GAP_LEN : C_MAX1;
   localparam int C_CNT_W = $clog2(C_MAX2 + 1);
   localparam int C_GAP_RELOAD = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_DATA = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [C_CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic                dout_q, dout_d;
   logic                dout_valid_q, dout_valid_d;
   logic                sync_mark_q, sync_mark_d;
   logic                frame_done_q, frame_done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         shreg_q      <= '0;
         dout_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         sync_mark_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shreg_q      <= shreg_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         sync_mark_q  <= sync_mark_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Outputs are computed for the cycle after the edge, so each branch
   // prepares the bit that the next state/count will be presenting.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shreg_d      = shreg_q;
      dout_d       = 1'b0;
      dout_valid_d = 1'b0;
      sync_mark_d  = 1'b0;
      frame_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               state_d      = S_PRE;
               cnt_d        = C_CNT_W'(3);
               shreg_d      = bus.in_data;
               dout_d       = PREAMBLE[3];
               dout_valid_d = 1'b1;
            end
         end
         S_PRE: begin
            dout_valid_d = 1'b1;
            if (cnt_q != '0) begin
               cnt_d       = cnt_q - 1'b1;
               dout_d      = PREAMBLE[cnt_d[1:0]];
               sync_mark_d = (cnt_d == '0);
            end else begin
               state_d      = S_DATA;
               cnt_d        = C_CNT_W'(DATA_W - 1);
               dout_d       = shreg_q[DATA_W-1];
               shreg_d      = shreg_q << 1;
               frame_done_d = (DATA_W == 1);
            end
         end
         S_DATA: begin
            if (cnt_q != '0) begin
               cnt_d        = cnt_q - 1'b1;
               dout_valid_d = 1'b1;
               dout_d       = shreg_q[DATA_W-1];
               shreg_d      = shreg_q << 1;
               frame_done_d = (cnt_d == '0);
            end else if (GAP_LEN > 0) begin
               state_d = S_GAP;
               cnt_d   = C_CNT_W'(C_GAP_RELOAD);
            end else begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         S_GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            shreg_d = '0;
         end
      endcase
   end

   assign bus.in_ready   = (state_q == S_IDLE);
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.sync_mark  = sync_mark_q;
   assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_tx_preamble.sv
// ============================================================================
// tb_seq_tx_preamble : scoreboard bench for the serial preamble transmitter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_tx_preamble;

   localparam int         DW  = 8;
   localparam int         GL  = 2;
   localparam logic [3:0] PRE = 4'b1101;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_tx_preamble_if #(.DATA_W(DW)) bus  ();
   seq_tx_preamble_if #(.DATA_W(1))  bus1 ();

   seq_tx_preamble #(.DATA_W(DW), .GAP_LEN(GL), .PREAMBLE(PRE)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   seq_tx_preamble #(.DATA_W(1), .GAP_LEN(0), .PREAMBLE(PRE)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_hs = 0;
   bit prev_held = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit b;
      bit sm;
      bit fd;
      bit det;
   } exp_t;
   exp_t q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Reference: the frame is the preamble followed by the payload bits; a
   // 1101 detector fires wherever the last four line bits spell 1101. The
   // line carries at least three zeros before every frame (idle + gap).
   function automatic void push_frame(input logic [DW-1:0] d);
      bit         s[$];
      logic [3:0] p;
      int         w;
      exp_t       e;
      p = PRE;
      for (int i = 0; i < 4; i++)  s.push_back(p[3-i]);
      for (int i = 0; i < DW; i++) s.push_back(d[DW-1-i]);
      w = 0;
      foreach (s[i]) begin
         w     = ((w << 1) | int'(s[i])) & 15;
         e.b   = s[i];
         e.sm  = (i == 3);
         e.fd  = (i == DW + 3);
         e.det = (w == 13);
         q.push_back(e);
      end
   endfunction

   // Monitor: pops one expected bit for every valid line cycle
   logic [3:0] hist = 4'b0;
   initial begin
      exp_t e;
      logic det;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hist = 4'b0;
         end else begin
            hist = {hist[2:0], bus.dout};
            det  = (hist == 4'b1101);
            if (bus.dout_valid) begin
               if (q.size() == 0) begin
                  chk("unexpected_valid_bit", 32'd1, 32'd0);
               end else begin
                  e = q.pop_front();
                  chk("dout", 32'(bus.dout), 32'(e.b));
                  chk("sync_mark", 32'(bus.sync_mark), 32'(e.sm));
                  chk("frame_done", 32'(bus.frame_done), 32'(e.fd));
                  chk("detector_hit", 32'(det), 32'(e.det));
               end
            end else begin
               chk("idle_line", {29'd0, bus.dout, bus.sync_mark, bus.frame_done}, 32'd0);
               chk("idle_detector", 32'(det), 32'd0);
            end
         end
      end
   end

   // Called on a falling edge; returns on the falling edge where in_ready is back.
   task automatic send(input logic [DW-1:0] d, input bit hold_valid, input logic [DW-1:0] noise);
      int n;
      n = 0;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         chk("handshake_timeout", 32'd0, 32'd1);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      push_frame(d);
      #1;
      if (prev_held) chk("b2b_spacing", 32'(cyc - last_hs), 32'(4 + DW + GL + 1));
      last_hs   = cyc;
      prev_held = hold_valid;
      if (!hold_valid) bus.in_valid = 1'b0;
      bus.in_data = noise;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.in_ready && n < 1000);
      chk("ready_latency", 32'(n), 32'(5 + DW + GL));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [4:0]    s1;
      logic [DW-1:0] d;
      bit            hold;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus1.in_valid = 1'b0;
      bus1.in_data  = '0;

      repeat (3) @(negedge clk);
      chk("reset_outputs", {27'd0, bus.in_ready, bus.dout, bus.dout_valid,
                            bus.sync_mark, bus.frame_done}, 32'b10000);
      chk("reset_outputs_w1", {27'd0, bus1.in_ready, bus1.dout, bus1.dout_valid,
                               bus1.sync_mark, bus1.frame_done}, 32'b10000);
      rst_n = 1'b1;
      @(negedge clk);

      send(8'hA5, 1'b0, 8'h5A);
      send(8'h3C, 1'b1, 8'h00);
      send(8'hFF, 1'b0, 8'h00);
      send(8'h00, 1'b0, 8'h00);
      send(8'hD0, 1'b0, 8'h00);

      // Abandon a frame mid-payload with an asynchronous reset
      bus.in_data  = 8'h6B;
      bus.in_valid = 1'b1;
      @(posedge clk);
      push_frame(8'h6B);
      #1 bus.in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      chk("pre_reset_valid", 32'(bus.dout_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_clear", {29'd0, bus.dout, bus.dout_valid, bus.frame_done}, 32'd0);
      q.delete();
      prev_held = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 32'(bus.in_ready), 32'd1);
      send(8'h81, 1'b0, 8'h7E);

      for (int i = 0; i < 40; i++) begin
         d    = DW'($urandom);
         hold = 1'($urandom_range(0, 1));
         send(d, hold, DW'($urandom));
         if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      bus.in_valid = 1'b0;
      prev_held    = 1'b0;

      // Single-bit payload, no gap
      @(negedge clk);
      s1 = {PRE, 1'b1};
      bus1.in_data  = 1'b1;
      bus1.in_valid = 1'b1;
      @(posedge clk);
      #1 bus1.in_valid = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         chk("w1_dout", 32'(bus1.dout), 32'(s1[5-i]));
         chk("w1_flags", {28'd0, bus1.in_ready, bus1.dout_valid, bus1.sync_mark, bus1.frame_done},
             {28'd0, 1'b0, 1'b1, 1'(i == 4), 1'(i == 5)});
      end
      @(negedge clk);
      chk("w1_ready_return", {30'd0, bus1.in_ready, bus1.dout_valid}, 32'b10);

      repeat (20) @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
